clock_en_ctrl: RTL and testbench
================================

// Module: clock_en_ctrl
// PURPOSE
//  Upstream controller for clock_gating_model: generates the registered clock
//  enable that feeds its i_clock_en. Enables the gated clock on demand, waits a
//  wake-up delay before declaring the gated domain ready, and holds the clock on
//  for an idle timeout after activity stops. Counts gated-off cycles for power stats.
// PARAMETERS
//  WAKE_CYC      2    cycles o_clock_en is high before o_ready rises; legal >=1
//  IDLE_TIMEOUT  16   idle cycles in HOLD before clock is gated off; legal >=1
//  CNT_W         8    width of timers and of o_gated_cycles; must hold both params
// PORTS
//  i_clk           in   1      free-running clock (ungated side)
//  i_rstn          in   1      asynchronous active-low reset
//  i_req           in   1      activity request from producer (level)
//  i_busy          in   1      gated domain still working (level)
//  i_force_on      in   1      keep clock enabled regardless of activity
//  i_stat_clr      in   1      synchronous clear of o_gated_cycles
//  o_clock_en      out  1      registered enable to clock_gating_model.i_clock_en
//  o_ready         out  1      gated domain clocked and settled
//  o_state         out  2      FSM state (debug)
//  o_gated_cycles  out  CNT_W  saturating count of cycles with o_clock_en==0
// BEHAVIOUR
//  - Reset (async on i_rstn low): state=IDLE, o_clock_en=0, o_ready=0,
//    timers=0, o_gated_cycles=0. All outputs are flops; no comb paths to outputs.
//  - act = i_req | i_busy | i_force_on.
//  - States: IDLE=2'd0, WAKE=2'd1, RUN=2'd2, HOLD=2'd3.
//  - IDLE: o_clock_en=0, o_ready=0. act -> WAKE; o_clock_en=1 from next edge
//    (1-cycle latency act -> enable).
//  - WAKE: o_clock_en=1, o_ready=0; timer counts WAKE_CYC cycles, then -> RUN,
//    o_ready=1 on the edge that enters RUN. Entered at edge T, RUN at T+WAKE_CYC.
//    act dropping during WAKE does not abort; WAKE always completes.
//  - RUN: o_clock_en=1, o_ready=1. !act -> HOLD, load timer=IDLE_TIMEOUT.
//  - HOLD: o_clock_en=1, o_ready=1; timer decrements each cycle with !act.
//    act -> RUN (timer discarded). timer==1 and !act -> IDLE; o_clock_en and
//    o_ready drop on that edge. Enable stays high exactly IDLE_TIMEOUT cycles
//    after the first idle cycle of RUN.
//  - Simultaneous act and timeout expiry in HOLD: act wins (-> RUN).
//  - i_force_on high holds FSM out of IDLE; it never skips WAKE.
//  - o_gated_cycles: +1 each cycle o_clock_en==0, saturates at 2^CNT_W-1;
//    i_stat_clr clears to 0 and wins over increment in the same cycle.
//  - Reset mid-operation: o_clock_en drops immediately (async); downstream
//    latch-based gate absorbs the glitch-free low transition.
//  - o_clock_en only changes on posedge i_clk so downstream latch sees stable
//    enable during clock-high phase.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE/WAKE/RUN/HOLD) as localparams
//    or `defines for reuse by bench and debug monitor.
//  - Single module; one natural sub-module: sat_counter (CNT_W, inc, clr) for
//    o_gated_cycles. Timer for WAKE/HOLD shared, inline in FSM.
// TESTING  (WAKE_CYC=2, IDLE_TIMEOUT=16, CNT_W=8; bench drives clock_gating_model)
//  1 Reset: i_rstn=0 for 3 cycles -> o_clock_en=0, o_ready=0, o_state=0,
//    o_gated_cycles=0; release -> o_gated_cycles increments 1/cycle.
//  2 Wake: i_req=1 at edge T -> o_clock_en=1 at T+1, o_ready=1 at T+3,
//    o_state=RUN; o_clk toggles from T+1.
//  3 Timeout: i_req drops in RUN at edge T -> HOLD at T+1, o_clock_en=0 and
//    o_state=IDLE at T+17; o_clk stops.
//  4 Re-wake in HOLD: i_busy=1 pulse when timer==1 -> state RUN, enable held,
//    o_ready never drops; then full 16-cycle timeout restarts.
//  5 Stats: 300 cycles idle -> o_gated_cycles=255 saturated; i_stat_clr=1 ->
//    0 next cycle, even while increment pending.
//  6 Async reset in RUN: i_rstn low mid-cycle -> o_clock_en=0 immediately,
//    no o_clk glitch; after release with i_force_on=1 -> WAKE then RUN again.

Source files
------------

// File: rtl/clock_en_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_en_ctrl_pkg
//  Description : Shared state encodings and small helpers for the clock
//                enable controller. It can also be imported by debug monitors
//                that decode o_state.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_en_ctrl_pkg;

  // State type, two bits wide to match the o_state debug port.
  typedef logic [1:0] state_t;

  // Encodings are fixed so that external monitors can decode o_state.
  localparam state_t c_st_idle = 2'd0;  // clock gated off
  localparam state_t c_st_wake = 2'd1;  // clock on, domain settling
  localparam state_t c_st_run  = 2'd2;  // clock on, activity present
  localparam state_t c_st_hold = 2'd3;  // clock on, idle timeout running

  // The gated clock runs in every state except IDLE.
  function automatic logic state_clocked(input state_t st);
    return (st != c_st_idle);
  endfunction

  // The domain counts as ready only after WAKE has completed.
  function automatic logic state_ready(input state_t st);
    return (st == c_st_run) || (st == c_st_hold);
  endfunction

endpackage : clock_en_ctrl_pkg
`default_nettype wire

// File: rtl/clock_en_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_en_ctrl_sat_counter
//  Description : Saturating up-counter with a synchronous clear. The clear
//                takes priority over an increment in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_en_ctrl_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  // All-ones is the saturation point.
  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == c_max);

  // Count up on request, stick at all-ones, and let clear win over increment.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : clock_en_ctrl_sat_counter
`default_nettype wire

// File: rtl/clock_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_en_ctrl
//  Description : Generates the registered clock enable for a latch-based
//                clock gate. It turns the gated clock on when there is
//                activity, waits WAKE_CYC cycles before flagging the domain
//                ready, and keeps the clock running for IDLE_TIMEOUT idle
//                cycles before gating it off. It also counts the cycles
//                during which the clock was gated off.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_en_ctrl
  import clock_en_ctrl_pkg::*;
#(
  parameter int WAKE_CYC     = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  input  logic             i_busy,
  input  logic             i_force_on,
  input  logic             i_stat_clr,
  output logic             o_clock_en,
  output logic             o_ready,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_gated_cycles
);

  // Timer reload values. WAKE and HOLD share a single down-counter; both
  // phases end on the cycle in which the counter reads one.
  localparam logic [CNT_W-1:0] c_wake_load = CNT_W'(WAKE_CYC);
  localparam logic [CNT_W-1:0] c_idle_load = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] c_timer_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             r_clock_en;
  logic             r_ready;
  logic             w_clock_en_nxt;
  logic             w_ready_nxt;
  logic             w_act;
  logic             w_timer_last;

  // Any of these keeps, or brings, the gated clock on.
  assign w_act        = i_req | i_busy | i_force_on;
  assign w_timer_last = (r_timer <= c_timer_one);

  // State register, shared timer and output flops. The outputs are
  // registered from the next state so they change only on the rising edge
  // and have no combinational path from the inputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= c_st_idle;
      r_timer    <= '0;
      r_clock_en <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_clock_en <= w_clock_en_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      c_st_idle: begin
        // Any activity starts the wake sequence, including i_force_on;
        // the WAKE phase is never skipped.
        if (w_act) begin
          w_state_nxt = c_st_wake;
          w_timer_nxt = c_wake_load;
        end else begin
          w_timer_nxt = '0;
        end
      end
      c_st_wake: begin
        // WAKE always runs to completion, even if activity goes away.
        if (w_timer_last) begin
          w_state_nxt = c_st_run;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      c_st_run: begin
        // The first idle cycle arms the idle timeout.
        if (!w_act) begin
          w_state_nxt = c_st_hold;
          w_timer_nxt = c_idle_load;
        end
      end
      c_st_hold: begin
        // Activity beats expiry when both happen in the same cycle.
        if (w_act) begin
          w_state_nxt = c_st_run;
          w_timer_nxt = '0;
        end else if (w_timer_last) begin
          w_state_nxt = c_st_idle;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Output decode of the next state, registered in the state register block.
  always_comb begin
    w_clock_en_nxt = state_clocked(w_state_nxt);
    w_ready_nxt    = state_ready(w_state_nxt);
  end

  // Power statistics: count every cycle in which the clock was gated off.
  clock_en_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_gated_cnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_inc   (~r_clock_en),
    .i_clr   (i_stat_clr),
    .o_count (o_gated_cycles)
  );

  assign o_clock_en = r_clock_en;
  assign o_ready    = r_ready;
  assign o_state    = r_state;

endmodule : clock_en_ctrl
`default_nettype wire

// File: tb/tb_clock_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_en_ctrl
//  Description : Self-checking bench for clock_en_ctrl. It includes a
//                behavioural latch-based clock gate so that the gated clock
//                can be observed, and a cycle-level reference model kept in
//                terms of wake progress and idle streak length.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_en_ctrl;

  localparam int WAKE_CYC     = 2;
  localparam int IDLE_TIMEOUT = 16;
  localparam int CNT_W        = 8;
  localparam int SAT_MAX      = 255;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic             clk;
  logic             rstn;
  logic             req;
  logic             busy;
  logic             force_on;
  logic             stat_clr;
  logic             clock_en;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] gated_cycles;

  int checks;
  int errors;

  // Reference model: the clock is on, wake progress in cycles, and the
  // number of consecutive idle cycles seen since the domain became ready.
  bit m_en;
  bit m_ready;
  int m_wake;
  int m_idle;
  int m_cnt;

  // Behavioural latch-based clock gate, standing in for the downstream gate.
  logic en_lat;
  logic gclk;
  int   gclk_edges;

  clock_en_ctrl #(
    .WAKE_CYC     (WAKE_CYC),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req          (req),
    .i_busy         (busy),
    .i_force_on     (force_on),
    .i_stat_clr     (stat_clr),
    .o_clock_en     (clock_en),
    .o_ready        (ready),
    .o_state        (state),
    .o_gated_cycles (gated_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_latch begin
    if (!clk) en_lat = clock_en;
  end
  assign gclk = clk & en_lat;

  initial gclk_edges = 0;
  always @(posedge gclk) gclk_edges = gclk_edges + 1;

  function automatic logic [1:0] m_state();
    if (!m_en)          return S_IDLE;
    else if (!m_ready)  return S_WAKE;
    else if (m_idle==0) return S_RUN;
    else                return S_HOLD;
  endfunction

  task automatic model_reset();
    m_en = 0; m_ready = 0; m_wake = 0; m_idle = 0; m_cnt = 0;
  endtask

  // Advance one rising edge, update the model, then settle 1 time unit.
  task automatic tick();
    bit act;
    bit was_en;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      act    = req | busy | force_on;
      was_en = m_en;
      if (stat_clr)                        m_cnt = 0;
      else if (!was_en && m_cnt < SAT_MAX) m_cnt = m_cnt + 1;
      if (!m_en) begin
        if (act) begin m_en = 1; m_wake = 0; end
      end else if (!m_ready) begin
        m_wake = m_wake + 1;
        if (m_wake == WAKE_CYC) begin m_ready = 1; m_idle = 0; end
      end else if (act) begin
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
        // One idle cycle leaves RUN, then IDLE_TIMEOUT cycles elapse in HOLD.
        if (m_idle == IDLE_TIMEOUT + 1) begin
          m_en = 0; m_ready = 0; m_idle = 0;
        end
      end
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 0; req = 0; busy = 0; force_on = 0; stat_clr = 0;
    ticks(3);
    checks++;
    if (clock_en !== 1'b0 || ready !== 1'b0 || state !== S_IDLE || gated_cycles !== '0) begin
      errors++;
      $display("FAIL reset: en=%b rdy=%b st=%0d cnt=%0d, required 0/0/0/0",
               clock_en, ready, state, gated_cycles);
    end
    rstn = 1;
    ticks(3);
    checks++;
    if (gated_cycles !== 8'd3) begin
      errors++;
      $display("FAIL reset_count: cnt=%0d, required 3", gated_cycles);
    end
  endtask

  task automatic test_wake();
    int e0;
    req = 1;
    tick();
    checks++;
    if (clock_en !== 1'b1 || ready !== 1'b0 || state !== S_WAKE) begin
      errors++;
      $display("FAIL wake_t1: en=%b rdy=%b st=%0d, required 1/0/1", clock_en, ready, state);
    end
    tick();
    checks++;
    if (ready !== 1'b0 || state !== S_WAKE) begin
      errors++;
      $display("FAIL wake_t2: rdy=%b st=%0d, required 0/1", ready, state);
    end
    tick();
    checks++;
    if (clock_en !== 1'b1 || ready !== 1'b1 || state !== S_RUN) begin
      errors++;
      $display("FAIL wake_t3: en=%b rdy=%b st=%0d, required 1/1/2", clock_en, ready, state);
    end
    e0 = gclk_edges;
    ticks(4);
    checks++;
    if (gclk_edges - e0 != 4) begin
      errors++;
      $display("FAIL wake_gclk: edges=%0d, required 4", gclk_edges - e0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    req = 0;
    tick();
    checks++;
    if (state !== S_HOLD || clock_en !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: st=%0d en=%b, required 3/1", state, clock_en);
    end
    ticks(15);
    checks++;
    if (state !== S_HOLD || clock_en !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_last: st=%0d en=%b rdy=%b, required 3/1/1", state, clock_en, ready);
    end
    tick();
    checks++;
    if (state !== S_IDLE || clock_en !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_off: st=%0d en=%b rdy=%b, required 0/0/0", state, clock_en, ready);
    end
    tick();
    e0 = gclk_edges;
    ticks(4);
    checks++;
    if (gclk_edges != e0) begin
      errors++;
      $display("FAIL timeout_gclk: edges=%0d, required 0", gclk_edges - e0);
    end
  endtask

  task automatic test_rewake_hold();
    bit dropped;
    req = 1;
    ticks(3);
    req = 0;
    ticks(16);
    checks++;
    if (state !== S_HOLD) begin
      errors++;
      $display("FAIL rewake_pre: st=%0d, required 3", state);
    end
    busy = 1;
    tick();
    busy = 0;
    checks++;
    if (state !== S_RUN || clock_en !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rewake_run: st=%0d en=%b rdy=%b, required 2/1/1", state, clock_en, ready);
    end
    dropped = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ready !== 1'b1 || clock_en !== 1'b1) dropped = 1;
    end
    checks++;
    if (dropped || state !== S_HOLD) begin
      errors++;
      $display("FAIL rewake_restart: dropped=%b st=%0d, required 0/3", dropped, state);
    end
    tick();
    checks++;
    if (state !== S_IDLE || clock_en !== 1'b0) begin
      errors++;
      $display("FAIL rewake_off: st=%0d en=%b, required 0/0", state, clock_en);
    end
  endtask

  task automatic test_stats();
    ticks(300);
    checks++;
    if (gated_cycles !== 8'd255) begin
      errors++;
      $display("FAIL stats_sat: cnt=%0d, required 255", gated_cycles);
    end
    stat_clr = 1;
    tick();
    stat_clr = 0;
    checks++;
    if (gated_cycles !== 8'd0) begin
      errors++;
      $display("FAIL stats_clr: cnt=%0d, required 0", gated_cycles);
    end
    tick();
    checks++;
    if (gated_cycles !== 8'd1) begin
      errors++;
      $display("FAIL stats_resume: cnt=%0d, required 1", gated_cycles);
    end
  endtask

  task automatic test_async_reset();
    req = 1;
    ticks(3);
    @(posedge clk);
    #1;
    req = 0;
    #1;
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if (clock_en !== 1'b0 || ready !== 1'b0 || state !== S_IDLE || gated_cycles !== '0) begin
      errors++;
      $display("FAIL async_rst: en=%b rdy=%b st=%0d cnt=%0d, required 0/0/0/0",
               clock_en, ready, state, gated_cycles);
    end
    checks++;
    if (gclk !== 1'b1) begin
      errors++;
      $display("FAIL async_glitch: gclk=%b during high phase, required 1", gclk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gclk !== 1'b0) begin
      errors++;
      $display("FAIL async_gclk_low: gclk=%b, required 0", gclk);
    end
    rstn = 1;
    force_on = 1;
    tick();
    checks++;
    if (state !== S_WAKE || clock_en !== 1'b1) begin
      errors++;
      $display("FAIL force_wake: st=%0d en=%b, required 1/1", state, clock_en);
    end
    ticks(2);
    checks++;
    if (state !== S_RUN || ready !== 1'b1) begin
      errors++;
      $display("FAIL force_run: st=%0d rdy=%b, required 2/1", state, ready);
    end
    ticks(30);
    checks++;
    if (state !== S_RUN) begin
      errors++;
      $display("FAIL force_hold: st=%0d, required 2", state);
    end
    force_on = 0;
  endtask

  task automatic test_random();
    int mode;
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 30; c++) begin
        case (mode)
          0:       req = ($urandom_range(0, 99) < 3);
          1:       req = $urandom_range(0, 1) == 1;
          default: req = ($urandom_range(0, 99) < 10);
        endcase
        busy     = (mode == 1) && ($urandom_range(0, 99) < 20);
        force_on = (mode == 2) && ($urandom_range(0, 99) < 5);
        stat_clr = ($urandom_range(0, 99) < 2);
        tick();
        checks++;
        if (clock_en !== m_en || ready !== m_ready || state !== m_state() ||
            gated_cycles !== CNT_W'(m_cnt)) begin
          errors++;
          $display("FAIL random seg%0d cyc%0d: en=%b rdy=%b st=%0d cnt=%0d, required %b/%b/%0d/%0d",
                   seg, c, clock_en, ready, state, gated_cycles,
                   m_en, m_ready, m_state(), m_cnt);
        end
      end
    end
    req = 0; busy = 0; force_on = 0; stat_clr = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 0; req = 0; busy = 0; force_on = 0; stat_clr = 0;
    model_reset();
    test_reset();
    test_wake();
    test_timeout();
    test_rewake_hold();
    test_stats();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clock_en_ctrl
`default_nettype wire
